// File: rtl/depth_test_writer.sv
// Z-buffer stage behind the rasterizer: nearer-wins depth test, framebuffer write issue,
// and the per-frame clear of depth buffer and framebuffer.
//
// state  | meaning
// S_IDLE | accepting fragments into the 4-stage pipe
// S_DRAIN| clear requested, waiting for in-flight fragments to retire
// S_CLEAR| sweeping one address per cycle, depth <= farthest, pixel <= CLEAR_COLOR
module depth_test_writer #(
   parameter int COORD_WIDTH     = 32,
   parameter int DEPTH_BIT_WIDTH = 16,
   parameter int COLOR_WIDTH     = 16,
   parameter int FB_WIDTH        = 320,
   parameter int FB_HEIGHT       = 180,
   parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
   input  logic                                    clk_in,
   input  logic                                    rst_in,
   input  logic                                    drawing,
   input  logic [COORD_WIDTH-1:0]                  x,
   input  logic [COORD_WIDTH-1:0]                  y,
   input  logic [DEPTH_BIT_WIDTH-1:0]              depth,
   input  logic [COLOR_WIDTH-1:0]                  color_in,
   input  logic                                    clear_start,
   output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]   fb_addr,
   output logic [COLOR_WIDTH-1:0]                  fb_data,
   output logic                                    fb_we,
   output logic                                    clearing,
   output logic                                    clear_done,
   output logic [31:0]                             pass_count,
   output logic [31:0]                             fail_count,
   output logic [31:0]                             drop_count
);

   localparam int NPIX = FB_WIDTH * FB_HEIGHT;
   localparam int AW   = $clog2(NPIX);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
   localparam logic [AW-1:0] FBW       = AW'(FB_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

   state_t state, state_nx;
   logic [AW-1:0] clr_addr, clr_addr_nx;
   logic start_clear;

   logic                       v1, v2, v3, v4;
   logic [AW-1:0]              x1, y1, a2, a3, a4;
   logic [DEPTH_BIT_WIDTH-1:0] d1, d2, d3, d4, d5;
   logic [COLOR_WIDTH-1:0]     c1, c2, c3, c4;
   logic                       pass4, w5;
   logic [DEPTH_BIT_WIDTH-1:0] rd3, stored_eff;
   logic                       pass3;

   logic in_range, accept, drop, pipe_busy;

   logic                       ram_we;
   logic [AW-1:0]              ram_waddr;
   logic [DEPTH_BIT_WIDTH-1:0] ram_wdata;
   logic [DEPTH_BIT_WIDTH-1:0] ram [0:NPIX-1];

   assign in_range  = (x < COORD_WIDTH'(FB_WIDTH)) && (y < COORD_WIDTH'(FB_HEIGHT));
   assign accept    = drawing && in_range && (state == S_IDLE) && !clearing;
   assign drop      = drawing && !accept;
   assign pipe_busy = v1 || v2 || v3 || v4;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state    <= S_IDLE;
         clr_addr <= '0;
      end else begin
         state    <= state_nx;
         clr_addr <= clr_addr_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      clr_addr_nx = clr_addr;
      start_clear = 1'b0;
      case (state)
         S_IDLE: begin
            if (clear_start) begin
               start_clear = 1'b1;
               clr_addr_nx = '0;
               state_nx    = (pipe_busy || accept) ? S_DRAIN : S_CLEAR;
            end
         end
         S_DRAIN: begin
            if (!pipe_busy) state_nx = S_CLEAR;
         end
         S_CLEAR: begin
            clr_addr_nx = clr_addr + 1'b1;
            if (clr_addr == LAST_ADDR) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Older writes not yet visible in the RAM read: stage 4 (younger) beats the output stage.
   always_comb begin
      stored_eff = rd3;
      if (v4 && pass4 && (a4 == a3))
         stored_eff = d4;
      else if (w5 && (fb_addr == a3))
         stored_eff = d5;
   end
   assign pass3 = d3 < stored_eff;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
         x1 <= '0; y1 <= '0; d1 <= '0; c1 <= '0;
         a2 <= '0; d2 <= '0; c2 <= '0;
         a3 <= '0; d3 <= '0; c3 <= '0;
         a4 <= '0; d4 <= '0; c4 <= '0; pass4 <= 1'b0;
      end else begin
         v1 <= accept;
         if (accept) begin
            x1 <= AW'(x);
            y1 <= AW'(y);
            d1 <= depth;
            c1 <= color_in;
         end
         v2 <= v1;
         a2 <= y1 * FBW + x1;
         d2 <= d1;
         c2 <= c1;
         v3 <= v2;
         a3 <= a2;
         d3 <= d2;
         c3 <= c2;
         v4    <= v3;
         pass4 <= pass3;
         a4    <= a3;
         d4    <= d3;
         c4    <= c3;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
         w5         <= 1'b0;
         d5         <= '0;
         clearing   <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         clearing   <= (state == S_CLEAR);
         clear_done <= clearing && (fb_addr == LAST_ADDR);
         if (state == S_CLEAR) begin
            fb_we   <= 1'b1;
            fb_addr <= clr_addr;
            fb_data <= CLEAR_COLOR;
            w5      <= 1'b0;
         end else begin
            fb_we <= v4 && pass4;
            w5    <= v4 && pass4;
            d5    <= d4;
            if (v4 && pass4) begin
               fb_addr <= a4;
               fb_data <= c4;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pass_count <= '0;
         fail_count <= '0;
         drop_count <= '0;
      end else begin
         pass_count <= (start_clear ? 32'd0 : pass_count) + 32'(v3 && pass3);
         fail_count <= (start_clear ? 32'd0 : fail_count) + 32'(v3 && !pass3);
         drop_count <= (start_clear ? 32'd0 : drop_count) + 32'(drop);
      end
   end

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = a4;
      ram_wdata = d4;
      if (!rst_in) begin
         if (state == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '1;
         end else if (v4 && pass4) begin
            ram_we = 1'b1;
         end
      end
   end

   // Depth RAM kept free of reset so it maps onto block memory.
   always_ff @(posedge clk_in) begin
      if (ram_we) ram[ram_waddr] <= ram_wdata;
      rd3 <= ram[a2];
   end

endmodule

// File: tb/tb_depth_test_writer.sv
// Scoreboard bench for depth_test_writer: expected framebuffer writes are queued by the
// stimulus, and a negedge monitor pops and compares every fb_we it observes.
module tb_depth_test_writer;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        drawing = 1'b0;
   logic [31:0] x = '0, y = '0;
   logic [15:0] depth = '0, color_in = '0;
   logic        clear_start = 1'b0;
   logic [15:0] fb_addr;
   logic [15:0] fb_data;
   logic        fb_we, clearing, clear_done;
   logic [31:0] pass_count, fail_count, drop_count;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_e;
   int clr_cycles = 0;
   int done_cnt   = 0;

   depth_test_writer dut (
      .clk_in(clk_in), .rst_in(rst_in), .drawing(drawing), .x(x), .y(y),
      .depth(depth), .color_in(color_in), .clear_start(clear_start),
      .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .clearing(clearing),
      .clear_done(clear_done), .pass_count(pass_count), .fail_count(fail_count),
      .drop_count(drop_count)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (clearing) clr_cycles++;
      if (clear_done) done_cnt++;
      if (fb_we) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %0h expected no write", fb_addr, fb_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("fb_write{addr,data}", {fb_addr, fb_data}, mon_e);
         end
      end
   end

   task automatic expect_wr(input int a, input logic [15:0] d);
      exp_q.push_back({16'(a), d});
   endtask

   task automatic frag(input int fx, input int fy, input logic [15:0] d, input logic [15:0] c);
      drawing  = 1'b1;
      x        = 32'(fx);
      y        = 32'(fy);
      depth    = d;
      color_in = c;
      @(posedge clk_in); #1;
   endtask

   task automatic idle(input int n);
      drawing     = 1'b0;
      clear_start = 1'b0;
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic check_counts(input string tag, input int p, input int f, input int d);
      check({tag, "_pass_count"}, pass_count, 32'(p));
      check({tag, "_fail_count"}, fail_count, 32'(f));
      check({tag, "_drop_count"}, drop_count, 32'(d));
   endtask

   task automatic wait_clear_addr(input string name, input int a);
      logic found;
      found = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk_in);
         if (clearing && fb_we && fb_addr == 16'(a)) begin
            found = 1'b1;
            break;
         end
      end
      check(name, 32'(found), 32'd1);
   endtask

   initial begin
      int done_before;
      logic got_done;

      // Reset state
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_fb_we", 32'(fb_we), 32'd0);
      check("rst_clearing", 32'(clearing), 32'd0);
      check("rst_clear_done", 32'(clear_done), 32'd0);
      check("rst_fb_addr", 32'(fb_addr), 32'd0);
      check_counts("rst", 0, 0, 0);
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      idle(2);

      // Full clear
      for (int i = 0; i < 57600; i++) expect_wr(i, 16'h0000);
      clr_cycles  = 0;
      done_cnt    = 0;
      clear_start = 1'b1;
      @(posedge clk_in); #1;
      clear_start = 1'b0;
      got_done = 1'b0;
      for (int k = 0; k < 60000; k++) begin
         @(negedge clk_in);
         if (clear_done) begin
            got_done = 1'b1;
            check("done_fb_we_low", 32'(fb_we), 32'd0);
            break;
         end
      end
      check("clear_done_seen", 32'(got_done), 32'd1);
      idle(3);
      check("clear_cycles", 32'(clr_cycles), 32'd57600);
      check("clear_done_pulses", 32'(done_cnt), 32'd1);
      check("clear_queue_empty", 32'(exp_q.size()), 32'd0);
      check_counts("after_clear", 0, 0, 0);

      // Single fragment, latency 4
      expect_wr(1610, 16'hF800);
      frag(10, 5, 16'h4000, 16'hF800);
      drawing = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("t2_we_before_4", 32'(fb_we), 32'd0);
      @(posedge clk_in);
      @(negedge clk_in);
      check("t2_we_at_4", 32'(fb_we), 32'd1);
      @(posedge clk_in); #1;
      idle(4);
      check_counts("t2", 1, 0, 0);

      // Back-to-back same pixel
      expect_wr(1610, 16'h1111);
      expect_wr(1610, 16'h3333);
      frag(10, 5, 16'h3000, 16'h1111);
      frag(10, 5, 16'h3800, 16'h2222);
      frag(10, 5, 16'h2000, 16'h3333);
      idle(8);
      check_counts("t3", 3, 1, 0);
      // stored depth now 2000: equal fails, one nearer passes
      expect_wr(1610, 16'h5555);
      frag(10, 5, 16'h2000, 16'h4444);
      frag(10, 5, 16'h1FFF, 16'h5555);
      idle(8);
      check_counts("t3_ram", 4, 2, 0);

      // Equal depth twice at (0,0)
      expect_wr(0, 16'hC001);
      frag(0, 0, 16'h1234, 16'hC001);
      frag(0, 0, 16'h1234, 16'hC002);
      idle(8);
      check_counts("t5", 5, 3, 0);

      // One-cycle spacing (output-stage forward)
      expect_wr(321, 16'hA001);
      expect_wr(321, 16'hA002);
      frag(1, 1, 16'h5000, 16'hA001);
      idle(1);
      frag(1, 1, 16'h4000, 16'hA002);
      idle(1);
      frag(1, 1, 16'h4800, 16'hA003);
      idle(8);
      check_counts("gap1", 7, 4, 0);

      // Two-cycle spacing (RAM path)
      expect_wr(2, 16'hB001);
      frag(2, 0, 16'h00A0, 16'hB001);
      idle(2);
      frag(2, 0, 16'h00A0, 16'hB002);
      idle(8);
      check_counts("gap2", 8, 5, 0);

      // Out of range
      frag(320, 0, 16'h0000, 16'hDEAD);
      frag(0, 180, 16'h0000, 16'hDEAD);
      idle(8);
      check_counts("oob", 8, 5, 2);
      check("frag_queue_empty", 32'(exp_q.size()), 32'd0);

      // Clear with a fragment in flight, drop during clearing, reset at address 100
      expect_wr(3, 16'h7777);
      for (int i = 0; i <= 100; i++) expect_wr(i, 16'h0000);
      frag(3, 0, 16'h0000, 16'h7777);
      drawing     = 1'b0;
      clear_start = 1'b1;
      @(posedge clk_in); #1;
      clear_start = 1'b0;
      done_before = done_cnt;
      wait_clear_addr("t6_reach_50", 50);
      drawing = 1'b1;
      x = 32'd4;
      y = 32'd0;
      depth = 16'h0000;
      color_in = 16'hEEEE;
      @(posedge clk_in); #1;
      drawing = 1'b0;
      wait_clear_addr("t6_reach_100", 100);
      check_counts("t6_mid_clear", 1, 0, 1);
      rst_in = 1'b1;
      @(negedge clk_in);
      check("t6_rst_clearing", 32'(clearing), 32'd0);
      check("t6_rst_fb_we", 32'(fb_we), 32'd0);
      check_counts("t6_rst", 0, 0, 0);
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      idle(4);
      check("t6_no_clear_done", 32'(done_cnt), 32'(done_before));
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      // Restart clear from address 0, abort again after a few writes
      for (int i = 0; i <= 20; i++) expect_wr(i, 16'h0000);
      clear_start = 1'b1;
      @(posedge clk_in); #1;
      clear_start = 1'b0;
      wait_clear_addr("t6_restart_reach_20", 20);
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      idle(3);
      check("t6_restart_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t6_restart_fb_we", 32'(fb_we), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
